// File: rtl/match_evt_pkg.sv
// Shared constants and helpers for the match event logger.
// Optional feature macro: MATCH_EVT_TAG_EN adds a 3-bit sequence tag to
// each entry. The entry is then 8 bits wide instead of 5.
package match_evt_pkg;

  localparam int unsigned COUNT_W = 5;
  localparam int unsigned TAG_W   = 3;

`ifdef MATCH_EVT_TAG_EN
  localparam int unsigned ENTRY_W = COUNT_W + TAG_W;
`else
  localparam int unsigned ENTRY_W = COUNT_W;
`endif

  typedef logic [ENTRY_W-1:0] entry_t;

  // The upstream match flag is registered one cycle after its count, so the
  // count that produced the match is one behind the current count.
  function automatic logic [COUNT_W-1:0] match_count(input logic [COUNT_W-1:0] c);
    return c - COUNT_W'(1);
  endfunction

endpackage

// File: rtl/match_event_logger_if.sv
// Event capture and consumer bus for match_event_logger.
//   count_in, match_pulse : event source (upstream counter)
//   evt_data, evt_valid, evt_ready : FIFO head handshake
//   level, overflow : status
// The master modport is the logger, and the slave modport is its environment.
interface match_event_logger_if
  import match_evt_pkg::*;
#(
  parameter int unsigned DEPTH = 4
);
  logic [COUNT_W-1:0]           count_in;
  logic                         match_pulse;
  logic [ENTRY_W-1:0]           evt_data;
  logic                         evt_valid;
  logic                         evt_ready;
  logic [$clog2(DEPTH):0]       level;
  logic                         overflow;

  modport master (
    input  count_in, match_pulse, evt_ready,
    output evt_data, evt_valid, level, overflow
  );

  modport slave (
    output count_in, match_pulse, evt_ready,
    input  evt_data, evt_valid, level, overflow
  );
endinterface

// File: rtl/match_evt_fifo_ctrl.sv
// Pointer and level bookkeeping for the event FIFO.
//   clk, rst  : clock and asynchronous active-high reset
//   push_req  : an event is presented this cycle
//   pop_req   : the consumer is ready
//   wr_en     : the push is accepted. Write storage at wr_ptr.
//   wr_ptr, rd_ptr : storage addresses (they wrap modulo DEPTH)
//   level, valid, overflow : status outputs
module match_evt_fifo_ctrl #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_req,
  input  logic             pop_req,
  output logic             wr_en,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [LVL_W-1:0] level,
  output logic             valid,
  output logic             overflow
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             overflow_q, overflow_d;
  logic             push, pop;

  always_comb begin
    pop  = (level_q != '0) && pop_req;
    // When the FIFO is full, a push is accepted only if a pop frees the slot in the same cycle.
    push = push_req && ((level_q < LVL_W'(DEPTH)) || pop);

    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d    = level_q;
    if (push && !pop) level_d = level_q + LVL_W'(1);
    else if (!push && pop) level_d = level_q - LVL_W'(1);
    overflow_d = overflow_q | (push_req & ~push);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  assign wr_en    = push;
  assign wr_ptr   = wr_ptr_q;
  assign rd_ptr   = rd_ptr_q;
  assign level    = level_q;
  assign valid    = (level_q != '0);
  assign overflow = overflow_q;

endmodule

// File: rtl/match_event_logger.sv
// Match event logger. It captures match events from a 5-bit match counter
// into a FIFO of DEPTH entries (a power of two, 2..16). Each entry is the
// count that produced the match. The head entry is offered to a
// valid/ready consumer.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : match_event_logger_if.master (event input, FIFO head, status)
// Macro MATCH_EVT_TAG_EN: each entry also carries a 3-bit sequence tag in
// bits [7:5]. The tag advances on every event, including dropped events.
module match_event_logger
  import match_evt_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  match_event_logger_if.master bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  entry_t           mem_q [DEPTH];
  entry_t           entry;
  logic             wr_en;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

`ifdef MATCH_EVT_TAG_EN
  logic [TAG_W-1:0] tag_q, tag_d;

  always_comb begin
    tag_d = bus.match_pulse ? tag_q + TAG_W'(1) : tag_q;
    entry = {tag_q, match_count(bus.count_in)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tag_q <= '0;
    else     tag_q <= tag_d;
  end
`else
  always_comb begin
    entry = match_count(bus.count_in);
  end
`endif

  match_evt_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .push_req (bus.match_pulse),
    .pop_req  (bus.evt_ready),
    .wr_en    (wr_en),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .level    (bus.level),
    .valid    (bus.evt_valid),
    .overflow (bus.overflow)
  );

  // Storage is not reset. A reset clears the pointers, and that discards the contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr] <= entry;
  end

  assign bus.evt_data = mem_q[rd_ptr];

endmodule

// File: tb/tb_match_event_logger.sv
module tb_match_event_logger;
  import match_evt_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
`ifdef MATCH_EVT_TAG_EN
  localparam int TAG_EN = 1;
`else
  localparam int TAG_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  match_event_logger_if #(.DEPTH(DEPTH)) bus ();
  match_event_logger #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: a queue of expected entries, a sticky drop flag, and a tag count.
  int mq[$];
  bit m_ovf = 0;
  int m_tag = 0;

  function automatic int exp_entry(int cnt, int tag);
    int v;
    v = (cnt + 31) % 32;
    v = v + (tag % 8) * 32 * TAG_EN;
    return v % (1 << ENTRY_W);
  endfunction

  task automatic model_clear();
    mq.delete();
    m_ovf = 0;
    m_tag = 0;
  endtask

  // Applies one clock edge to the model and to the DUT, then waits 1 time unit past the edge.
  task automatic tick();
    bit pop, push;
    pop  = (mq.size() > 0) && bus.evt_ready;
    push = bus.match_pulse && ((mq.size() < DEPTH) || pop);
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(exp_entry(int'(bus.count_in), m_tag));
    else if (bus.match_pulse) m_ovf = 1;
    if (bus.match_pulse) m_tag = (m_tag + 1) % 8;
    @(posedge clk);
    #1;
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    bus.match_pulse = 1'b0;
    bus.evt_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    bus.count_in = '0;
    bus.match_pulse = 1'b0;
    bus.evt_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (bus.evt_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.evt_valid); else pass_cnt++;
    total_cnt++; if (bus.level !== '0) $display("FAIL reset_level: got %0d expected 0", bus.level); else pass_cnt++;
    total_cnt++; if (bus.overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", bus.overflow); else pass_cnt++;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_basic();
    bus.count_in = 5'd9; bus.match_pulse = 1'b1; bus.evt_ready = 1'b0;
    tick();
    bus.match_pulse = 1'b0;
    total_cnt++; if (bus.evt_valid !== 1'b1) $display("FAIL basic_valid: got %b expected 1", bus.evt_valid); else pass_cnt++;
    total_cnt++; if (bus.evt_data[4:0] !== 5'd8) $display("FAIL basic_data: got %0d expected 8", bus.evt_data[4:0]); else pass_cnt++;
    total_cnt++; if (bus.level !== LVL_W'(1)) $display("FAIL basic_level: got %0d expected 1", bus.level); else pass_cnt++;
    total_cnt++; if (int'(bus.evt_data) !== mq[0]) $display("FAIL basic_entry: got %0d expected %0d", bus.evt_data, mq[0]); else pass_cnt++;
    bus.evt_ready = 1'b1;
    tick();
    bus.evt_ready = 1'b0;
    total_cnt++; if (bus.evt_valid !== 1'b0) $display("FAIL basic_pop_valid: got %b expected 0", bus.evt_valid); else pass_cnt++;
    total_cnt++; if (bus.level !== '0) $display("FAIL basic_pop_level: got %0d expected 0", bus.level); else pass_cnt++;
    // A ready signal while the FIFO is empty does nothing.
    bus.evt_ready = 1'b1;
    tick();
    bus.evt_ready = 1'b0;
    total_cnt++; if (bus.level !== '0) $display("FAIL empty_ready_level: got %0d expected 0", bus.level); else pass_cnt++;
  endtask

  task automatic test_count_zero();
    bus.count_in = 5'd0; bus.match_pulse = 1'b1;
    tick();
    bus.match_pulse = 1'b0;
    total_cnt++; if (bus.evt_data[4:0] !== 5'd31) $display("FAIL zero_wrap_data: got %0d expected 31", bus.evt_data[4:0]); else pass_cnt++;
    total_cnt++; if (int'(bus.evt_data) !== mq[0]) $display("FAIL zero_wrap_entry: got %0d expected %0d", bus.evt_data, mq[0]); else pass_cnt++;
  endtask

  task automatic test_full_push_pop();
    sync_reset();
    for (int i = 0; i < 4; i++) begin
      bus.count_in = 5'(10 + i); bus.match_pulse = 1'b1; bus.evt_ready = 1'b0;
      tick();
    end
    bus.count_in = 5'd14; bus.match_pulse = 1'b1; bus.evt_ready = 1'b1;
    tick();
    bus.match_pulse = 1'b0; bus.evt_ready = 1'b0;
    total_cnt++; if (bus.level !== LVL_W'(4)) $display("FAIL fullpp_level: got %0d expected 4", bus.level); else pass_cnt++;
    total_cnt++; if (bus.overflow !== 1'b0) $display("FAIL fullpp_overflow: got %b expected 0", bus.overflow); else pass_cnt++;
    total_cnt++; if (int'(bus.evt_data) !== exp_entry(11, 1)) $display("FAIL fullpp_head: got %0d expected %0d", bus.evt_data, exp_entry(11, 1)); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      bus.evt_ready = 1'b1;
      total_cnt++; if (int'(bus.evt_data) !== mq[0]) $display("FAIL fullpp_drain: got %0d expected %0d", bus.evt_data, mq[0]); else pass_cnt++;
      tick();
    end
    bus.evt_ready = 1'b0;
    total_cnt++; if (int'(bus.evt_data) !== -1 && bus.evt_valid !== 1'b0) $display("FAIL fullpp_empty: got %b expected 0", bus.evt_valid); else pass_cnt++;
  endtask

  task automatic test_overflow();
    sync_reset();
    for (int i = 1; i <= 5; i++) begin
      bus.count_in = 5'(i); bus.match_pulse = 1'b1; bus.evt_ready = 1'b0;
      tick();
    end
    bus.match_pulse = 1'b0;
    total_cnt++; if (bus.level !== LVL_W'(4)) $display("FAIL ovf_level: got %0d expected 4", bus.level); else pass_cnt++;
    total_cnt++; if (bus.overflow !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", bus.overflow); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      total_cnt++; if (bus.evt_data[4:0] !== 5'(k)) $display("FAIL ovf_entry: got %0d expected %0d", bus.evt_data[4:0], k); else pass_cnt++;
      total_cnt++; if (int'(bus.evt_data) !== exp_entry(k + 1, k)) $display("FAIL ovf_tag: got %0d expected %0d", bus.evt_data, exp_entry(k + 1, k)); else pass_cnt++;
      bus.evt_ready = 1'b1;
      tick();
      bus.evt_ready = 1'b0;
    end
    bus.count_in = 5'd20; bus.match_pulse = 1'b1;
    tick();
    bus.match_pulse = 1'b0;
    total_cnt++; if (int'(bus.evt_data) !== exp_entry(20, 5)) $display("FAIL ovf_next_tag: got %0d expected %0d", bus.evt_data, exp_entry(20, 5)); else pass_cnt++;
    total_cnt++; if (bus.overflow !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", bus.overflow); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      bus.count_in = 5'(25 + i); bus.match_pulse = 1'b1;
      tick();
    end
    bus.match_pulse = 1'b0;
    total_cnt++; if (bus.level !== LVL_W'(3)) $display("FAIL arst_pre_level: got %0d expected 3", bus.level); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (bus.evt_valid !== 1'b0) $display("FAIL arst_valid: got %b expected 0", bus.evt_valid); else pass_cnt++;
    total_cnt++; if (bus.level !== '0) $display("FAIL arst_level: got %0d expected 0", bus.level); else pass_cnt++;
    total_cnt++; if (bus.overflow !== 1'b0) $display("FAIL arst_overflow: got %b expected 0", bus.overflow); else pass_cnt++;
    #2 rst = 1'b0;
    model_clear();
    bus.count_in = 5'd3; bus.match_pulse = 1'b1;
    tick();
    bus.match_pulse = 1'b0;
    total_cnt++; if (bus.level !== LVL_W'(1)) $display("FAIL first_push_level: got %0d expected 1", bus.level); else pass_cnt++;
    total_cnt++; if (int'(bus.evt_data) !== exp_entry(3, 0)) $display("FAIL first_push_data: got %0d expected %0d", bus.evt_data, exp_entry(3, 0)); else pass_cnt++;
    bus.evt_ready = 1'b1;
    tick();
    bus.evt_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.evt_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.count_in = 5'($urandom_range(0, 31)); bus.match_pulse = 1'b1;
      tick();
      total_cnt++; if (bus.level !== LVL_W'(mq.size())) $display("FAIL b2b_level: got %0d expected %0d", bus.level, mq.size()); else pass_cnt++;
      total_cnt++; if (int'(bus.evt_data) !== mq[0]) $display("FAIL b2b_data: got %0d expected %0d", bus.evt_data, mq[0]); else pass_cnt++;
    end
    bus.match_pulse = 1'b0;
    tick();
    bus.evt_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.count_in    = 5'($urandom_range(0, 31));
      bus.match_pulse = ($urandom_range(0, 9) < 6);
      bus.evt_ready   = ($urandom_range(0, 9) < 4);
      if (i == 200) begin
        bus.match_pulse = 1'b0;
        sync_reset();
      end
      tick();
      total_cnt++; if (bus.evt_valid !== (mq.size() != 0)) $display("FAIL rand_valid: got %b expected %0d", bus.evt_valid, mq.size() != 0); else pass_cnt++;
      total_cnt++; if (bus.level !== LVL_W'(mq.size())) $display("FAIL rand_level: got %0d expected %0d", bus.level, mq.size()); else pass_cnt++;
      total_cnt++; if (bus.overflow !== m_ovf) $display("FAIL rand_overflow: got %b expected %b", bus.overflow, m_ovf); else pass_cnt++;
      if (mq.size() != 0) begin
        total_cnt++; if (int'(bus.evt_data) !== mq[0]) $display("FAIL rand_data: got %0d expected %0d", bus.evt_data, mq[0]); else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_count_zero();
    test_full_push_pop();
    test_overflow();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
